// File: rtl/ice40_clkgen_pkg.sv
// ============================================================================
// Module      : ice40_clkgen_pkg
// Description : Shared constants, types and helpers for the iCE40 clock-chain
//               model (HFOSC divider + PLL40-style NCO).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ice40_clkgen_pkg;

    localparam int ACC_W            = 15;
    localparam int CLKHF_DIV_MAX    = 3;
    localparam int DIVR_MAX         = 15;
    localparam int DIVF_MAX         = 127;
    localparam int DIVQ_MAX         = 7;
    localparam int PU_CYCLES_MAX    = 255;
    localparam int LOCK_TOGGLES_MAX = 255;

    typedef logic [ACC_W-1:0] acc_t;

    // Effective NCO denominator: reference divider times 2^post-divider.
    function automatic int nco_den(input int divr, input int divq);
        return (divr + 1) << divq;
    endfunction

    // Bits needed to hold any value in 0..maxval.
    function automatic int cnt_width(input int maxval);
        int w;
        w = 1;
        while ((1 << w) <= maxval) w++;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ice40_hfosc_div.sv
// ============================================================================
// Module      : ice40_hfosc_div
// Description : Oscillator power-up counter and 2^(CLKHF_DIV+1) divider;
//               emits a one-cycle strobe on each CLKHF toggle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ice40_hfosc_div
    import ice40_clkgen_pkg::*;
#(
    parameter int CLKHF_DIV = 2,
    parameter int PU_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pu_i,
    input  logic en_i,
    output logic strobe_o,
    output logic clkhf_o
);

    localparam int PU_W  = cnt_width(PU_CYCLES_MAX);
    localparam int DIV_W = cnt_width((1 << CLKHF_DIV_MAX) - 1);
    localparam logic [PU_W-1:0]  PU_TC  = PU_W'(PU_CYCLES);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'((1 << CLKHF_DIV) - 1);

    logic [PU_W-1:0]  pu_cnt_q, pu_cnt_d;
    logic             pu_done_q, pu_done_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             clkhf_q, clkhf_d;
    logic             run;
    logic             term;

    always_comb begin
        run       = pu_i & pu_done_q & en_i;
        term      = run & (div_cnt_q == DIV_TC);
        pu_cnt_d  = pu_cnt_q;
        pu_done_d = pu_done_q;
        div_cnt_d = div_cnt_q;
        clkhf_d   = clkhf_q;
        if (!pu_i) begin
            pu_cnt_d  = '0;
            pu_done_d = 1'b0;
            div_cnt_d = '0;
            clkhf_d   = 1'b0;
        end else begin
            if (pu_cnt_q != PU_TC) pu_cnt_d = pu_cnt_q + 1'b1;
            pu_done_d = (pu_cnt_d == PU_TC);
            if (run)  div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
            if (term) clkhf_d   = ~clkhf_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pu_cnt_q  <= '0;
            pu_done_q <= 1'b0;
            div_cnt_q <= '0;
            clkhf_q   <= 1'b0;
        end else begin
            pu_cnt_q  <= pu_cnt_d;
            pu_done_q <= pu_done_d;
            div_cnt_q <= div_cnt_d;
            clkhf_q   <= clkhf_d;
        end
    end

    assign strobe_o = term;
    assign clkhf_o  = clkhf_q;

endmodule

`default_nettype wire

// File: rtl/ice40_clkgen_model.sv
// ============================================================================
// Module      : ice40_clkgen_model
// Description : iCE40 clock chain model: HFOSC divider feeding an NCO that
//               synthesizes PLLOUTCORE. Optional macro CLKGEN_LOCK_EN adds the
//               LOCK port and gates PLLOUTCORE until lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ice40_clkgen_model
    import ice40_clkgen_pkg::*;
#(
    parameter int CLKHF_DIV    = 2,
    parameter int DIVR         = 0,
    parameter int DIVF         = 15,
    parameter int DIVQ         = 5,
    parameter int PU_CYCLES    = 4,
    parameter int LOCK_TOGGLES = 8
) (
    input  logic REFERENCECLK,
    input  logic RESETB,
    input  logic CLKHFPU,
    input  logic CLKHFEN,
    input  logic BYPASS,
    output logic CLKHF,
    output logic PLLOUTCORE,
`ifdef CLKGEN_LOCK_EN
    output logic LOCK,
`endif
    output logic CFG_ERR
);

    localparam int   DEN_INT = nco_den(DIVR, DIVQ);
    localparam acc_t DEN     = acc_t'(DEN_INT);
    localparam acc_t INC     = acc_t'(DIVF + 1);
    localparam bit   OVER    = (DIVF + 1) > DEN_INT;

    logic strobe;
    logic clkhf_lvl;
    logic bypass_q;
    logic bypass_chg;
    acc_t acc_q, acc_d, acc_sum;
    logic pll_q, pll_d;
    logic nco_tog;

    ice40_hfosc_div #(
        .CLKHF_DIV (CLKHF_DIV),
        .PU_CYCLES (PU_CYCLES)
    ) u_hfosc_div (
        .clk_i    (REFERENCECLK),
        .rst_ni   (RESETB),
        .pu_i     (CLKHFPU),
        .en_i     (CLKHFEN),
        .strobe_o (strobe),
        .clkhf_o  (clkhf_lvl)
    );

    assign bypass_chg = BYPASS ^ bypass_q;

    // A BYPASS edge restarts the NCO phase without toggling the output.
    always_comb begin
        acc_sum = acc_q + INC;
        nco_tog = CLKHFPU & ~BYPASS & ~bypass_chg & strobe & (OVER | (acc_sum >= DEN));
        acc_d   = acc_q;
        pll_d   = pll_q;
        if (!CLKHFPU) begin
            acc_d = '0;
            pll_d = 1'b0;
        end else if (BYPASS) begin
            acc_d = '0;
            pll_d = clkhf_lvl;
        end else if (bypass_chg) begin
            acc_d = '0;
        end else if (strobe) begin
            if (OVER)                acc_d = '0;
            else if (acc_sum >= DEN) acc_d = acc_sum - DEN;
            else                     acc_d = acc_sum;
            if (nco_tog) pll_d = ~pll_q;
        end
    end

    always_ff @(posedge REFERENCECLK or negedge RESETB) begin
        if (!RESETB) begin
            bypass_q <= 1'b0;
            acc_q    <= '0;
            pll_q    <= 1'b0;
        end else begin
            bypass_q <= BYPASS;
            acc_q    <= acc_d;
            pll_q    <= pll_d;
        end
    end

`ifdef CLKGEN_LOCK_EN
    localparam int LK_W = cnt_width(LOCK_TOGGLES_MAX);
    localparam logic [LK_W-1:0] LOCK_TC = LK_W'(LOCK_TOGGLES);

    logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic            locked;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!CLKHFPU || !CLKHFEN || BYPASS || bypass_chg) lock_cnt_d = '0;
        else if (nco_tog && (lock_cnt_q != LOCK_TC))      lock_cnt_d = lock_cnt_q + 1'b1;
    end

    always_ff @(posedge REFERENCECLK or negedge RESETB) begin
        if (!RESETB) lock_cnt_q <= '0;
        else         lock_cnt_q <= lock_cnt_d;
    end

    assign locked     = (lock_cnt_q == LOCK_TC);
    assign LOCK       = locked;
    // Bypass output is never gated by lock status.
    assign PLLOUTCORE = pll_q & (locked | bypass_q);
`else
    assign PLLOUTCORE = pll_q;
`endif

    assign CLKHF   = clkhf_lvl;
    assign CFG_ERR = OVER;

endmodule

`default_nettype wire

// File: tb/tb_ice40_clkgen_model.sv
// ============================================================================
// Module      : tb_ice40_clkgen_model
// Description : Scoreboard bench for ice40_clkgen_model; three configurations
//               share random stimulus. Honours CLKGEN_LOCK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ice40_clkgen_model;

    // Instance configurations: default, DEN=4/INC=3, over-speed.
    localparam int C_D   [3] = '{2, 1, 0};
    localparam int C_PU  [3] = '{4, 3, 1};
    localparam int C_INC [3] = '{16, 3, 67};
    localparam int C_DEN [3] = '{32, 4, 64};
    localparam int C_LT  [3] = '{8, 5, 3};

    typedef struct packed {
        logic [2:0] hf;
        logic [2:0] pl;
        logic [2:0] lk;
        logic [2:0] ce;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstb, pu, en, byp;
    logic [2:0] clkhf, pll, cfgerr;
`ifdef CLKGEN_LOCK_EN
    logic [2:0] lock;
`endif

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_pu [3], m_run [3], m_k [3], m_lc [3];
    bit m_hf [3], m_pll [3], m_bp [3];

    always #5 clk = ~clk;

    ice40_clkgen_model #(.CLKHF_DIV(2), .DIVR(0), .DIVF(15), .DIVQ(5), .PU_CYCLES(4), .LOCK_TOGGLES(8)) u_a (
        .REFERENCECLK(clk), .RESETB(rstb), .CLKHFPU(pu), .CLKHFEN(en), .BYPASS(byp),
        .CLKHF(clkhf[0]), .PLLOUTCORE(pll[0]),
`ifdef CLKGEN_LOCK_EN
        .LOCK(lock[0]),
`endif
        .CFG_ERR(cfgerr[0]));

    ice40_clkgen_model #(.CLKHF_DIV(1), .DIVR(0), .DIVF(2), .DIVQ(2), .PU_CYCLES(3), .LOCK_TOGGLES(5)) u_b (
        .REFERENCECLK(clk), .RESETB(rstb), .CLKHFPU(pu), .CLKHFEN(en), .BYPASS(byp),
        .CLKHF(clkhf[1]), .PLLOUTCORE(pll[1]),
`ifdef CLKGEN_LOCK_EN
        .LOCK(lock[1]),
`endif
        .CFG_ERR(cfgerr[1]));

    ice40_clkgen_model #(.CLKHF_DIV(0), .DIVR(1), .DIVF(66), .DIVQ(5), .PU_CYCLES(1), .LOCK_TOGGLES(3)) u_c (
        .REFERENCECLK(clk), .RESETB(rstb), .CLKHFPU(pu), .CLKHFEN(en), .BYPASS(byp),
        .CLKHF(clkhf[2]), .PLLOUTCORE(pll[2]),
`ifdef CLKGEN_LOCK_EN
        .LOCK(lock[2]),
`endif
        .CFG_ERR(cfgerr[2]));

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: the k-th strobe since the last phase restart toggles
    // the output whenever floor(k*INC/DEN) advances.
    task automatic model_step(input bit r, input bit p, input bit e, input bit b);
        exp_t x;
        bit   running, strobe, old_hf, chg;
        for (int i = 0; i < 3; i++) begin
            if (!r || !p) begin
                m_pu[i] = 0; m_run[i] = 0; m_hf[i] = 0; m_k[i] = 0; m_pll[i] = 0; m_lc[i] = 0;
                m_bp[i] = r ? b : 1'b0;
            end else begin
                running = e && (m_pu[i] >= C_PU[i]);
                if (m_pu[i] < C_PU[i]) m_pu[i]++;
                strobe = 1'b0;
                if (running) begin
                    m_run[i]++;
                    strobe = (m_run[i] % (1 << C_D[i])) == 0;
                end
                old_hf = m_hf[i];
                if (strobe) m_hf[i] = !m_hf[i];
                chg     = (b != m_bp[i]);
                m_bp[i] = b;
                if (b) begin
                    m_pll[i] = old_hf; m_k[i] = 0; m_lc[i] = 0;
                end else if (chg) begin
                    m_k[i] = 0; m_lc[i] = 0;
                end else if (strobe) begin
                    m_k[i]++;
                    if ((C_INC[i] > C_DEN[i]) ||
                        ((m_k[i] * C_INC[i]) / C_DEN[i] != ((m_k[i] - 1) * C_INC[i]) / C_DEN[i])) begin
                        m_pll[i] = !m_pll[i];
                        m_lc[i]++;
                    end
                end
                if (!e) m_lc[i] = 0;
            end
            x.hf[i] = m_hf[i];
            x.lk[i] = (m_lc[i] >= C_LT[i]);
            x.ce[i] = (C_INC[i] > C_DEN[i]);
`ifdef CLKGEN_LOCK_EN
            x.pl[i] = m_pll[i] & (x.lk[i] | m_bp[i]);
`else
            x.pl[i] = m_pll[i];
`endif
        end
        q.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit p, input bit e, input bit b);
        @(negedge clk);
        rstb = r; pu = p; en = e; byp = b;
        if (!r) begin
            #1;
            chk("async_rst_clkhf", clkhf, 3'b000);
            chk("async_rst_pll", pll, 3'b000);
`ifdef CLKGEN_LOCK_EN
            chk("async_rst_lock", lock, 3'b000);
`endif
        end
        model_step(r, p, e, b);
    endtask

    // Monitor: compares every registered output shortly after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("clkhf", clkhf, e.hf);
                chk("pllout", pll, e.pl);
                chk("cfg_err", cfgerr, e.ce);
`ifdef CLKGEN_LOCK_EN
                chk("lock", lock, e.lk);
`endif
            end
        end
    end

    initial begin
        int kind, len;
        rstb = 1'b0; pu = 1'b0; en = 1'b0; byp = 1'b0;
        repeat (3) cyc(0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (150) cyc(1, 1, 1, 0);
        repeat (40)  cyc(1, 1, 1, 1);
        repeat (120) cyc(1, 1, 1, 0);
        repeat (20)  cyc(1, 1, 0, 0);
        repeat (40)  cyc(1, 1, 1, 0);
        #3 cyc(0, 1, 1, 0);
        repeat (60)  cyc(1, 1, 1, 0);
        repeat (6)   cyc(1, 0, 1, 0);
        repeat (60)  cyc(1, 1, 1, 0);
        for (int s = 0; s < 45; s++) begin
            kind = $urandom_range(0, 99);
            len  = $urandom_range(5, 70);
            for (int c = 0; c < len; c++) begin
                if (kind < 45)      cyc(1, 1, 1, 0);
                else if (kind < 60) cyc(1, 1, $urandom_range(0, 3) != 0, 0);
                else if (kind < 75) cyc(1, 1, 1, 1);
                else if (kind < 85) cyc(1, c >= 3, 1, 0);
                else if (kind < 92) cyc(c >= 2, 1, 1, 0);
                else cyc(1, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1);
            end
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
